// File: rtl/counter_ud_mod_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : counter_pkg
//  Brief   : Shared constants and helpers for the up/down counter family.
//  Revision: 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Overflow handling selectors for the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to address 'depth' distinct values (minimum 1)
    function automatic int clog2(input longint unsigned depth);
        int              bits;
        longint unsigned v;
        bits = 0;
        v    = (depth > 64'd1) ? depth - 64'd1 : 64'd1;
        while (v != 64'd0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_ud_mod_if.sv
`default_nettype none
// ============================================================================
//  Module  : counter_ud_mod_if
//  Brief   : Control/status bundle of the up/down counter.
//  Revision: 1.0 - initial release
// ============================================================================
interface counter_ud_mod_if #(
    parameter int WIDTH  = 34,
    parameter int STEP_W = 4
);
    logic              ena;
    logic              updown;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  count_out;
    logic              tc;
    logic              at_max;
    logic              at_zero;

    // Controller side: drives commands, observes count and flags
    modport master (
        output ena, updown, load, load_val, step,
        input  count_out, tc, at_max, at_zero
    );

    // Counter side
    modport slave (
        input  ena, updown, load, load_val, step,
        output count_out, tc, at_max, at_zero
    );
endinterface : counter_ud_mod_if
`default_nettype wire

// File: rtl/counter_ud_next.sv
`default_nettype none
// ============================================================================
//  Module  : counter_ud_next
//  Brief   : Pure combinational next-count and terminal-count computation.
//            All arithmetic is carried at WIDTH+1 bits so no sum or
//            difference truncates before it is compared against the limit.
//  Revision: 1.0 - initial release
// ============================================================================
module counter_ud_next
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 34,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              STEP_W   = 4,
    parameter int              SATURATE = MODE_WRAP
) (
    input  wire logic [WIDTH-1:0]  i_count,
    input  wire logic [STEP_W-1:0] i_step,
    input  wire logic              i_updown,
    output logic      [WIDTH-1:0]  o_next,
    output logic                   o_tc_next
);

    localparam logic [WIDTH:0] c_max = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0] c_mod = c_max + {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] w_count;
    logic [WIDTH:0] w_step;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_res;

    assign w_count = {1'b0, i_count};
    assign w_step  = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};
    assign w_sum   = w_count + w_step;

    // Step once in the requested direction, applying a single wrap or clamp
    always_comb begin
        w_res     = w_count;
        o_tc_next = 1'b0;
        if (i_updown) begin
            if (w_sum <= c_max) begin
                w_res = w_sum;
            end else if (SATURATE == MODE_SAT) begin
                w_res     = c_max;
                o_tc_next = (w_count != c_max);
            end else begin
                w_res     = w_sum - c_mod;
                o_tc_next = 1'b1;
            end
        end else begin
            if (w_count >= w_step) begin
                w_res = w_count - w_step;
            end else if (SATURATE == MODE_SAT) begin
                w_res     = '0;
                o_tc_next = (w_count != '0);
            end else begin
                w_res     = w_count + c_mod - w_step;
                o_tc_next = 1'b1;
            end
        end
        o_next = w_res[WIDTH-1:0];
    end

    // Top bit of the intermediate is always clear once reduced into range
    logic w_unused;
    assign w_unused = w_res[WIDTH];

endmodule : counter_ud_next
`default_nettype wire

// File: rtl/counter_ud_mod.sv
`default_nettype none
// ============================================================================
//  Module  : counter_ud_mod
//  Brief   : Parametrised synchronous up/down counter with modulus, variable
//            step, parallel load, wrap/saturate, terminal-count pulse and
//            at-limit flags. Priority per edge: rst > load > ena.
//  Revision: 1.0 - initial release
// ============================================================================
module counter_ud_mod
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 34,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              STEP_W   = 4,
    parameter int              SATURATE = MODE_WRAP
) (
    input  wire logic         clk,
    input  wire logic         rst,
    counter_ud_mod_if.slave   bus
);

    // Reject configurations where the single-correction arithmetic breaks
    if (WIDTH < 1 || WIDTH > 63) begin : g_bad_width
        $error("counter_ud_mod: WIDTH must be 1..63");
    end
    if (MAX_VAL == 64'd0 || MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
        $error("counter_ud_mod: MAX_VAL must be in 1..2**WIDTH-1");
    end
    if (((64'd1 << STEP_W) - 64'd1) > MAX_VAL) begin : g_bad_step
        $error("counter_ud_mod: 2**STEP_W-1 must not exceed MAX_VAL");
    end

    localparam logic [WIDTH:0] c_max = (WIDTH + 1)'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic [WIDTH-1:0] w_next;
    logic             w_tc_next;
    logic [WIDTH-1:0] w_load_clamped;

    counter_ud_next #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .STEP_W   (STEP_W),
        .SATURATE (SATURATE)
    ) u_next (
        .i_count   (r_count),
        .i_step    (bus.step),
        .i_updown  (bus.updown),
        .o_next    (w_next),
        .o_tc_next (w_tc_next)
    );

    // Out-of-range load values are clamped to the top of the range
    assign w_load_clamped = ({1'b0, bus.load_val} > c_max) ? c_max[WIDTH-1:0]
                                                          : bus.load_val;

    // Count register with rst > load > ena priority; tc lives one cycle only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (bus.load) begin
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
        end else if (bus.ena && (bus.step != '0)) begin
            r_count <= w_next;
            r_tc    <= w_tc_next;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign bus.count_out = r_count;
    assign bus.tc        = r_tc;
    assign bus.at_max    = (r_count == c_max[WIDTH-1:0]);
    assign bus.at_zero   = (r_count == '0);

endmodule : counter_ud_mod
`default_nettype wire

// File: tb/tb_counter_ud_mod.sv
`default_nettype none
// ============================================================================
//  Module  : tb_counter_ud_mod
//  Brief   : Directed self-checking bench: wrap and saturate instances at
//            WIDTH=8/MAX_VAL=9/STEP_W=2 plus a full-range 34-bit instance.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_counter_ud_mod;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    counter_ud_mod_if #(.WIDTH(8),  .STEP_W(2)) if_a ();
    counter_ud_mod_if #(.WIDTH(8),  .STEP_W(2)) if_b ();
    counter_ud_mod_if #(.WIDTH(34), .STEP_W(4)) if_c ();

    counter_ud_mod #(.WIDTH(8), .MAX_VAL(9), .STEP_W(2), .SATURATE(0)) u_wrap (
        .clk (clk), .rst (rst), .bus (if_a.slave)
    );
    counter_ud_mod #(.WIDTH(8), .MAX_VAL(9), .STEP_W(2), .SATURATE(1)) u_sat (
        .clk (clk), .rst (rst), .bus (if_b.slave)
    );
    counter_ud_mod #(.WIDTH(34), .MAX_VAL(64'h3_FFFF_FFFF), .STEP_W(4), .SATURATE(0)) u_compat (
        .clk (clk), .rst (rst), .bus (if_c.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int up_cnt [5];
        int up_tc  [5];
        int dn_cnt [6];
        int dn_tc  [6];
        up_cnt = '{0, 3, 6, 9, 2};
        up_tc  = '{1, 0, 0, 0, 1};
        dn_cnt = '{9, 7, 5, 3, 1, 9};
        dn_tc  = '{1, 0, 0, 0, 0, 1};

        if_a.ena = 0; if_a.updown = 0; if_a.load = 0; if_a.load_val = '0; if_a.step = '0;
        if_b.ena = 0; if_b.updown = 0; if_b.load = 0; if_b.load_val = '0; if_b.step = '0;
        if_c.ena = 0; if_c.updown = 0; if_c.load = 0; if_c.load_val = '0; if_c.step = '0;

        // Reset state
        tick(); tick();
        check("rst_count", 64'(if_a.count_out), 64'd0);
        check("rst_tc",    64'(if_a.tc),        64'd0);
        check("rst_zero",  64'(if_a.at_zero),   64'd1);
        check("rst_max",   64'(if_a.at_max),    64'd0);
        check("rst_c_cnt", 64'(if_c.count_out), 64'd0);
        rst = 1'b0;

        // Reset mid-count
        if_a.load = 1; if_a.load_val = 8'd5; tick();
        check("t1_load5", 64'(if_a.count_out), 64'd5);
        if_a.load = 0; if_a.ena = 1; if_a.updown = 1; if_a.step = 2'd1; rst = 1'b1; tick();
        check("t1_rst_cnt",  64'(if_a.count_out), 64'd0);
        check("t1_rst_tc",   64'(if_a.tc),        64'd0);
        check("t1_rst_zero", 64'(if_a.at_zero),   64'd1);
        rst = 1'b0; tick();
        check("t1_resume1", 64'(if_a.count_out), 64'd1);
        tick();
        check("t1_resume2", 64'(if_a.count_out), 64'd2);

        // Wrap up, step 3 from 7
        if_a.load = 1; if_a.load_val = 8'd7; tick();
        check("t2_load7", 64'(if_a.count_out), 64'd7);
        if_a.load = 0; if_a.step = 2'd3; if_a.updown = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t2_cnt%0d", i), 64'(if_a.count_out), 64'(up_cnt[i]));
            check($sformatf("t2_tc%0d", i),  64'(if_a.tc),        64'(up_tc[i]));
        end

        // Wrap down, step 2 from 1
        if_a.load = 1; if_a.load_val = 8'd1; tick();
        check("t3_load1", 64'(if_a.count_out), 64'd1);
        if_a.load = 0; if_a.step = 2'd2; if_a.updown = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t3_cnt%0d", i), 64'(if_a.count_out), 64'(dn_cnt[i]));
            check($sformatf("t3_tc%0d", i),  64'(if_a.tc),        64'(dn_tc[i]));
            check($sformatf("t3_max%0d", i), 64'(if_a.at_max),    (dn_cnt[i] == 9) ? 64'd1 : 64'd0);
        end

        // Priority and clamp: load beats ena, over-range load clamps
        if_a.load = 1; if_a.ena = 1; if_a.load_val = 8'd200; if_a.updown = 1; if_a.step = 2'd1; tick();
        check("t5_clamp", 64'(if_a.count_out), 64'd9);
        check("t5_clamp_tc", 64'(if_a.tc), 64'd0);
        if_a.load = 0; if_a.load_val = 8'd3; tick();
        check("t5_wrap_after_clamp", 64'(if_a.count_out), 64'd0);
        if_a.step = 2'd0; tick();
        check("t5_step0_hold", 64'(if_a.count_out), 64'd0);
        if_a.ena = 0; if_a.step = 2'd2; tick();
        check("t5_ena0_hold", 64'(if_a.count_out), 64'd0);
        if_a.load = 1; if_a.load_val = 8'd6; tick();
        check("t5_load6", 64'(if_a.count_out), 64'd6);
        rst = 1'b1; if_a.load = 1; if_a.load_val = 8'd4; tick();
        check("t5_rst_over_load", 64'(if_a.count_out), 64'd0);
        rst = 1'b0; if_a.load = 0;

        // Saturate up: 8 -> 9,9,9 with a single tc
        if_b.load = 1; if_b.load_val = 8'd8; tick();
        check("t4_load8", 64'(if_b.count_out), 64'd8);
        if_b.load = 0; if_b.ena = 1; if_b.updown = 1; if_b.step = 2'd3;
        tick();
        check("t4_up_c0", 64'(if_b.count_out), 64'd9);
        check("t4_up_t0", 64'(if_b.tc),        64'd1);
        tick();
        check("t4_up_c1", 64'(if_b.count_out), 64'd9);
        check("t4_up_t1", 64'(if_b.tc),        64'd0);
        tick();
        check("t4_up_c2", 64'(if_b.count_out), 64'd9);
        check("t4_up_t2", 64'(if_b.tc),        64'd0);
        check("t4_at_max", 64'(if_b.at_max),   64'd1);

        // Saturate down: 2 -> 0,0 with a single tc
        if_b.load = 1; if_b.load_val = 8'd2; tick();
        check("t4_load2", 64'(if_b.count_out), 64'd2);
        if_b.load = 0; if_b.updown = 0;
        tick();
        check("t4_dn_c0", 64'(if_b.count_out), 64'd0);
        check("t4_dn_t0", 64'(if_b.tc),        64'd1);
        tick();
        check("t4_dn_c1", 64'(if_b.count_out), 64'd0);
        check("t4_dn_t1", 64'(if_b.tc),        64'd0);
        check("t4_at_zero", 64'(if_b.at_zero), 64'd1);
        if_b.ena = 0;

        // Full-range 34-bit compatibility, step 1
        if_c.load = 1; if_c.load_val = 34'd0; tick();
        check("t6_load0", 64'(if_c.count_out), 64'd0);
        if_c.load = 0; if_c.ena = 1; if_c.updown = 0; if_c.step = 4'd1; tick();
        check("t6_dn_cnt", 64'(if_c.count_out), 64'h3_FFFF_FFFF);
        check("t6_dn_tc",  64'(if_c.tc),        64'd1);
        check("t6_dn_max", 64'(if_c.at_max),    64'd1);
        if_c.updown = 1; tick();
        check("t6_up_cnt", 64'(if_c.count_out), 64'd0);
        check("t6_up_tc",  64'(if_c.tc),        64'd1);
        tick();
        check("t6_up1_cnt", 64'(if_c.count_out), 64'd1);
        check("t6_up1_tc",  64'(if_c.tc),        64'd0);
        if_c.updown = 0; tick();
        check("t6_back0", 64'(if_c.count_out), 64'd0);
        check("t6_back0_tc", 64'(if_c.tc), 64'd0);
        if_c.load = 1; if_c.load_val = 34'h2_0000_0000; tick();
        check("t6_load_hi", 64'(if_c.count_out), 64'h2_0000_0000);
        if_c.load = 0; tick();
        check("t6_hi_dn", 64'(if_c.count_out), 64'h1_FFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_counter_ud_mod
`default_nettype wire
